// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths and write-port types
package rf_pkg;
  localparam int RF_AW   = 3;
  localparam int RF_DW   = 16;
  localparam int RF_NREG = 1 << RF_AW;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  typedef struct packed {
    logic     en;
    rf_addr_t addr;
    rf_data_t data;
  } rf_wr_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// The first set request at or above i_ptr (wrapping) wins.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  int j;

  // Scanning from the far end lets the nearest requester overwrite the rest.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % N;
      if (i_req[j]) begin
        o_grant    = '0;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
        o_any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter for the register-file write port
// One registered stage drives wr_*; pending flags the register being written.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int AW      = RF_AW,
  parameter int DW      = RF_DW,
  parameter int NREG    = RF_NREG,
  parameter bit DROP_R0 = 1'b0,
  localparam int IW     = $clog2(NREQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_hold,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]    o_req_ready,
  output logic               o_wr_en,
  output logic [AW-1:0]      o_wr_addr,
  output logic [DW-1:0]      o_wr_data,
  output logic [IW-1:0]      o_grant_id,
  output logic [NREG-1:0]    o_pending
);
  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;

  logic            r_en;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic [IW-1:0]   r_gid;
  logic [IW-1:0]   r_ptr;

  assign w_req = i_hold ? '0 : i_req_valid;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_sel_addr = i_req_addr[w_idx*AW +: AW];
  assign w_sel_data = i_req_data[w_idx*DW +: DW];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_en   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_gid  <= '0;
      r_ptr  <= '0;
    end else if (w_any) begin
      r_addr <= w_sel_addr;
      r_data <= w_sel_data;
      r_gid  <= w_idx;
      // r0 writes are consumed from the requester but never reach the file.
      r_en   <= !(DROP_R0 && (w_sel_addr == '0));
      if (int'(w_idx) == NREQ - 1) r_ptr <= '0;
      else                         r_ptr <= w_idx + IW'(1);
    end else begin
      r_en <= 1'b0;
    end
  end

  always_comb begin
    o_pending = '0;
    if (r_en) o_pending[r_addr] = 1'b1;
  end

  assign o_req_ready = w_grant;
  assign o_wr_en     = r_en;
  assign o_wr_addr   = r_addr;
  assign o_wr_data   = r_data;
  assign o_grant_id  = r_gid;
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port of the 8x16 register file among NREQ write-back requesters (e.g. ALU, load unit, immediate/move unit).
- Uses a round-robin arbiter with a valid/ready handshake per requester and one registered output stage that drives wr_en/wr_addr/wr_data of the register file.
- Publishes a per-register pending-write bitmap so decode/issue logic can stall reads of a register whose write has not yet landed.

Parameters:
- NREQ, 3, number of write requesters (2..8).
- AW, 3, register address width.
- DW, 16, register data width.
- NREG, 8, number of registers (2**AW).
- DROP_R0, 0, when 1 a write to address 0 is accepted but never issued (r0 hardwired zero).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- hold  input  1  when 1, no new grants; the staged write still completes.
- req_valid  input  NREQ  requester i has a write pending.
- req_addr  input  NREQ*AW  packed destination addresses; requester i at bits [i*AW +: AW].
- req_data  input  NREQ*DW  packed write data; requester i at bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
- wr_en  output  1  write strobe to the register file.
- wr_addr  output  AW  write address to the register file.
- wr_data  output  DW  write data to the register file.
- grant_id  output  $clog2(NREQ)  index of the requester whose write is currently on wr_*.
- pending  output  NREG  bit a = 1 while a write to register a is on wr_* this cycle.

Behaviour:
- Reset (rst=1, asynchronous): wr_en=0, wr_addr=0, wr_data=0, grant_id=0, pending=0, round-robin pointer ptr=0. Any staged write is discarded and never issued. Outputs hold reset values until the first rising clk edge after rst deasserts.
- Arbitration is combinational each cycle.
  - Scan requesters starting at ptr upward, wrapping modulo NREQ. The first i with req_valid[i]=1 is granted: req_ready[i]=1, all other req_ready bits 0.
  - If hold=1 or no req_valid is set, req_ready=0.
  - req_ready never asserts for a requester whose req_valid=0.
- On a rising edge with an accepted transfer from requester g:
  - Staged wr_addr <= req_addr[g]; wr_data <= req_data[g]; grant_id <= g.
  - wr_en <= 1, except when DROP_R0=1 and req_addr[g]=0, in which case wr_en <= 0.
  - ptr <= (g+1) mod NREQ.
- With no accepted transfer: wr_en <= 0; wr_addr, wr_data and grant_id hold their values; ptr holds.
- Latency: exactly 1 cycle from acceptance to wr_en=1. Throughput: one write per cycle; back-to-back grants are allowed. There is no backpressure from the register file.
- pending is combinational from the stage: pending = wr_en ? (1 << wr_addr) : 0. At most one bit is set.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,... Any continuously valid requester is granted within NREQ cycles while hold=0.
- Requester obligation: a requester must keep req_valid, req_addr and req_data stable until it is granted. The arbiter does not check this.
- Same-address requests in one cycle: only the granted one is written this cycle; the others wait their turn. Register-file write order therefore equals grant order.
- hold rising while a write is staged: the staged write still issues; no new grant is made that cycle.
- ptr wrap: after granting NREQ-1, ptr = 0.

Decomposition:
- Package rf_pkg holds:
  - the AW/DW/NREG defaults as localparams;
  - typedef rf_addr_t (logic [AW-1:0]);
  - typedef rf_data_t (logic [DW-1:0]);
  - typedef rf_wr_t, a struct of {en, addr, data} shared with the register file instantiation.
- One sub-module: rr_pick. It is a purely combinational round-robin priority picker with inputs req vector and ptr, and outputs a one-hot grant and a grant index. rf_write_arbiter adds the stage, the pointer and pending.

Test Plan:
- Reset: rst=1 mid-cycle while requester 1 holds a write to addr 5 → wr_en=0 and pending=0 immediately (asynchronous). After release, the first valid requester is chosen starting from index 0.
- Single requester: req_valid=3'b010, addr=3, data=16'hBEEF → req_ready=3'b010 the same cycle. Next cycle wr_en=1, wr_addr=3, wr_data=16'hBEEF, grant_id=1, pending=8'b0000_1000.
- Round-robin: all three valid continuously for 6 cycles → grant sequence 0,1,2,0,1,2. wr_en stays high on every cycle from the 2nd to the 7th.
- Same-address contention: req0 writes addr 4 = 16'h0011 and req2 writes addr 4 = 16'h0022, both valid, ptr=0 → cycle+1 writes 16'h0011, cycle+2 writes 16'h0022. The final register value is 16'h0022.
- hold: hold=1 for 3 cycles with req1 valid → req_ready=0 throughout. After hold drops, req1 is granted within 1 cycle and a write already staged before hold still issues.
- DROP_R0=1: req0 writes addr 0 = 16'hFFFF → req_ready[0]=1 and ptr advances, but wr_en stays 0 and pending stays 0.
